// File: rtl/transition_player.sv
// Replays timestamped transition records onto sig_out, counting each record's
// delay in timebase ticks before applying its level.
module transition_player #(
  parameter int unsigned    WIDTH      = 16,
  parameter int unsigned    NCH        = 4,
  parameter logic [NCH-1:0] INIT_LEVEL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  input  logic             clr,
  input  logic             tick,
  input  logic             rec_valid,
  output logic             rec_ready,
  input  logic [WIDTH-1:0] rec_delta,
  input  logic [NCH-1:0]   rec_level,
  output logic [NCH-1:0]   sig_out,
  output logic             busy,
  output logic             underrun,
  output logic [15:0]      rec_count
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state;
  logic [WIDTH-1:0] remain;
  logic [NCH-1:0]   pend;
  logic             primed;
  logic             accept;

  assign rec_ready = run & ~clr & (state == IDLE);
  assign busy      = (state == WAIT);
  assign accept    = rec_valid & rec_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      remain    <= '0;
      pend      <= '0;
      primed    <= 1'b0;
      underrun  <= 1'b0;
      rec_count <= '0;
      sig_out   <= INIT_LEVEL;
    end else if (clr) begin
      // sig_out deliberately keeps its level across a clear
      state     <= IDLE;
      remain    <= '0;
      pend      <= '0;
      primed    <= 1'b0;
      underrun  <= 1'b0;
      rec_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            remain <= rec_delta;
            pend   <= rec_level;
            primed <= 1'b1;
            state  <= WAIT;
          end else if (run && primed && tick) begin
            underrun <= 1'b1;
          end
        end
        WAIT: begin
          if (run && tick) begin
            if (remain == '0) begin
              sig_out   <= pend;
              rec_count <= rec_count + 16'd1;
              state     <= IDLE;
            end else begin
              remain <= remain - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_transition_player.sv
// Scoreboard bench for transition_player: stimulus pushes expected applies,
// a monitor pops and checks them whenever rec_count advances.
module tb_transition_player;

  logic        clk, rstn, run, clr, tick, rec_valid, rec_ready;
  logic [15:0] rec_delta;
  logic [3:0]  rec_level, sig_out;
  logic        busy, underrun;
  logic [15:0] rec_count;

  transition_player #(.WIDTH(16), .NCH(4), .INIT_LEVEL(4'h0)) dut (
    .clk(clk), .rstn(rstn), .run(run), .clr(clr), .tick(tick),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_delta(rec_delta),
    .rec_level(rec_level), .sig_out(sig_out), .busy(busy),
    .underrun(underrun), .rec_count(rec_count)
  );

  typedef struct {
    logic [3:0]  lvl;
    logic [15:0] cnt;
    int          tk;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          tick_num = 0;
  int          cyc = 0;
  int          last_tick_cyc = -1;
  logic [15:0] exp_count = '0;
  logic [15:0] prev_cnt = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rec_count increment is one applied record
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rstn && rec_count == prev_cnt + 16'd1) begin
      if (q.size() == 0) begin
        chk("unexpected_apply", {16'h0, rec_count}, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("apply_level", {28'h0, sig_out}, {28'h0, e.lvl});
        chk("apply_count", {16'h0, rec_count}, {16'h0, e.cnt});
        chk("apply_tick", tick_num, e.tk);
        chk("apply_cycle", cyc, last_tick_cyc);
      end
    end
    prev_cnt = rec_count;
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick();
    @(negedge clk);
    tick = 1'b1;
    if (run) begin
      tick_num++;
      last_tick_cyc = cyc + 1;
    end
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic tick_gap();
    do_tick();
    idle(2);
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] l, input bit with_tick);
    int unsigned n = 0;
    bit ok = 1'b0;
    exp_t e;
    @(negedge clk);
    rec_valid = 1'b1;
    rec_delta = d;
    rec_level = l;
    while (!ok && n < 50) begin
      #1;
      if (rec_ready) ok = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (ok && with_tick) begin
      tick = 1'b1;
      tick_num++;
      last_tick_cyc = cyc + 1;
    end
    chk("accept", {31'h0, ok}, 32'h1);
    @(negedge clk);
    rec_valid = 1'b0;
    tick = 1'b0;
    if (ok) begin
      exp_count = exp_count + 16'd1;
      e.lvl = l;
      e.cnt = exp_count;
      e.tk  = tick_num + int'(d) + 1;
      q.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; run = 1'b1; clr = 1'b0; tick = 1'b0;
    rec_valid = 1'b0; rec_delta = '0; rec_level = '0;
    idle(2);
    chk("rst_sig_out", {28'h0, sig_out}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_underrun", {31'h0, underrun}, 32'h0);
    chk("rst_count", {16'h0, rec_count}, 32'h0);
    chk("rst_ready", {31'h0, rec_ready}, 32'h1);
    rstn = 1'b1;
    idle(1);

    // delta 3: applied on the 4th tick
    send(16'd3, 4'hA, 1'b0);
    chk("busy_after_accept", {31'h0, busy}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick_gap();
      chk("hold_before_apply", {28'h0, sig_out}, 32'h0);
    end
    tick_gap();

    // streaming records with tick spacing >= 2 clocks
    send(16'd0, 4'h1, 1'b0);
    tick_gap();
    send(16'd2, 4'h3, 1'b0);
    repeat (3) tick_gap();
    send(16'd0, 4'hF, 1'b0);
    tick_gap();
    chk("stream_no_underrun", {31'h0, underrun}, 32'h0);
    chk("stream_level", {28'h0, sig_out}, 32'hF);

    // underrun is sticky, clr clears it
    do_tick();
    chk("underrun_set", {31'h0, underrun}, 32'h1);
    chk("underrun_hold_level", {28'h0, sig_out}, 32'hF);
    send(16'd1, 4'h5, 1'b0);
    chk("underrun_sticky", {31'h0, underrun}, 32'h1);
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("ready_low_in_clr", {31'h0, rec_ready}, 32'h0);
    @(negedge clk);
    clr = 1'b0;
    q.delete();
    exp_count = '0;
    chk("clr_underrun", {31'h0, underrun}, 32'h0);
    chk("clr_count", {16'h0, rec_count}, 32'h0);
    chk("clr_busy", {31'h0, busy}, 32'h0);
    chk("clr_keeps_level", {28'h0, sig_out}, 32'hF);

    // run low freezes the countdown
    send(16'd5, 4'h6, 1'b0);
    repeat (2) tick_gap();
    run = 1'b0;
    repeat (10) tick_gap();
    chk("frozen_level", {28'h0, sig_out}, 32'hF);
    chk("frozen_busy", {31'h0, busy}, 32'h1);
    run = 1'b1;
    repeat (3) tick_gap();
    chk("resume_hold", {28'h0, sig_out}, 32'hF);
    tick_gap();

    // tick coincident with acceptance is not counted
    send(16'd0, 4'h9, 1'b1);
    idle(3);
    chk("same_cycle_tick_ignored", {28'h0, sig_out}, 32'h6);
    chk("same_cycle_busy", {31'h0, busy}, 32'h1);
    tick_gap();
    chk("same_cycle_no_underrun", {31'h0, underrun}, 32'h0);

    // asynchronous reset mid-WAIT
    send(16'd7, 4'hC, 1'b0);
    repeat (2) tick_gap();
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_sig_out", {28'h0, sig_out}, 32'h0);
    chk("async_busy", {31'h0, busy}, 32'h0);
    chk("async_count", {16'h0, rec_count}, 32'h0);
    q.delete();
    exp_count = '0;
    idle(2);
    rstn = 1'b1;
    send(16'd1, 4'h3, 1'b0);
    tick_gap();
    chk("post_reset_hold", {28'h0, sig_out}, 32'h0);
    tick_gap();

    idle(4);
    chk("queue_drained", q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/transition_player.md
# transition_player

Playback side of the transition logger. Accepts timestamped transition records (inter-transition delay plus new level) over a valid/ready handshake and regenerates the original multi-channel waveform on `sig_out`, timed by an external timebase strobe. It sits downstream of the record store/readback path and drives the replay pins. Delay counting runs inside the block; no external up/down counter is used.

## Interface
- `WIDTH`, 16, width of the delay field and of the internal countdown
- `NCH`, 4, number of replayed channels
- `INIT_LEVEL`, 0 (NCH bits), value of `sig_out` after reset
- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `run`  in  1  playback enable; low freezes all timing and acceptance
- `clr`  in  1  synchronous clear strobe (see Operation)
- `tick`  in  1  one-cycle timebase strobe; one tick is one delay unit
- `rec_valid`  in  1  record available
- `rec_ready`  out  1  block can accept a record this cycle
- `rec_delta`  in  WIDTH  ticks to wait before applying `rec_level`
- `rec_level`  in  NCH  new channel levels
- `sig_out`  out  NCH  replayed waveform, registered
- `busy`  out  1  a record is held and counting down
- `underrun`  out  1  sticky: timebase advanced with no record queued
- `rec_count`  out  16  number of records applied, wraps modulo 2^16

## Operation
- States: IDLE, WAIT.
- IDLE:
  - `rec_ready` = `run`.
  - On `rec_valid & rec_ready`: latch `remain` ← `rec_delta` and `pend` ← `rec_level`, set `primed`, then go to WAIT.
- WAIT:
  - `rec_ready` = 0 and `busy` = 1.
  - On `run & tick`:
    - if `remain` == 0: `sig_out` ← `pend`, `rec_count` ← `rec_count` + 1, go to IDLE;
    - else `remain` ← `remain` − 1.
- Delay semantics:
  - A record with delta N is applied on the (N+1)th tick counted after the acceptance edge.
  - A tick sampled in the same cycle as acceptance is not counted.
  - A record with delta 0 is applied on the next tick.
- Underrun:
  - Set in IDLE when `run & primed & tick` and no handshake occurs that cycle.
  - It is sticky. It does not alter `sig_out`, which holds its last level.
  - Ticks are never queued; the next accepted record starts a fresh countdown.
- `run` low:
  - In WAIT: `remain` is frozen and ticks are ignored; counting resumes where it left off.
  - In IDLE: no acceptance and no underrun.
- `clr` (priority over everything except `rstn`):
  - State goes to IDLE and any pending record is discarded.
  - `underrun`, `primed` and `rec_count` are cleared.
  - `sig_out` is unchanged.
- Reset values:
  - state IDLE, `sig_out` = `INIT_LEVEL`;
  - `busy`, `underrun`, `rec_count`, `remain`, `pend` and `primed` all 0;
  - `rec_ready` = `run` (combinational).
- `remain` is WIDTH bits and unsigned. Maximum delta is 2^WIDTH − 1, which gives a wait of 2^WIDTH ticks. There is no wrap inside a countdown.

## Timing
- `rec_ready` and `busy` are combinational from state, `run` and `clr`. `rec_ready` is 0 in any cycle where `clr` = 1.
- Acceptance takes effect at the clock edge where `rec_valid & rec_ready` is sampled high. `busy` rises the following cycle.
- `sig_out` and `rec_count` update at the edge where the terminal tick is sampled, and are visible one cycle after that tick.
- After a record is applied, the state is IDLE for at least one cycle. Back-to-back records therefore need `tick` spacing of at least 2 clocks for underrun-free replay.
- When the terminal tick falls in the same cycle as `clr`, `clr` wins: no apply and no count.
- `rstn` assertion mid-WAIT aborts immediately and asynchronously. Outputs return to reset values without waiting for a clock.

## Test plan
- Reset, `run`=1, accept delta=3 and level=4'hA, then pulse `tick` every 4 clocks. Required: `sig_out` stays 4'h0 through 3 ticks, becomes 4'hA one clock after the 4th tick, and `rec_count`=1.
- Stream records (0,1), (2,3), (0,F) with a record always offered. Required: `sig_out` steps 1→3→F on ticks 1, 4 and 5, and `underrun` stays 0.
- After one record is applied, hold `rec_valid`=0 and pulse `tick`. Required: `underrun`=1 the next cycle, `sig_out` is held, and `underrun` is still 1 after a later record is accepted. Pulse `clr`. Required: `underrun`=0 and `rec_count`=0.
- Accept delta=5, let 2 ticks pass, then drop `run` for 10 ticks and raise it again. Required: the level is applied on the 4th tick after `run` returns (6 counted ticks in total).
- Assert `tick` in the same cycle as acceptance of delta=0. Required: that tick is ignored and the level is applied on the next tick.
- Assert `rstn` low mid-WAIT. Required: `sig_out`=`INIT_LEVEL`, `busy`=0 and `rec_count`=0 immediately, and a new record is accepted normally after release.
